// File: rtl/io_pattern_gen.sv
// io_pattern_gen: steps a 12-entry byte pattern onto the user IO pads,
// holding each value for hold_cycles+1 clocks, with start/abort control.
// Optional macro IO_PATTERN_PROG_EN makes the pattern a writable register
// file (pat_we/pat_addr/pat_wdata); without it the pattern is a constant ROM.
module io_pattern_gen #(
  parameter int HOLD_W = 16,
  parameter int NSTEPS = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_cycles,
`ifdef IO_PATTERN_PROG_EN
  input  logic              pat_we,
  input  logic [3:0]        pat_addr,
  input  logic [7:0]        pat_wdata,
`endif
  output logic [7:0]        io_out,
  output logic [7:0]        io_oeb,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_STEP = 4'(NSTEPS - 1);

  function automatic logic [7:0] default_pat(input logic [3:0] idx);
    case (idx)
      4'd0:    default_pat = 8'h01;
      4'd1:    default_pat = 8'h02;
      4'd2:    default_pat = 8'h03;
      4'd3:    default_pat = 8'h04;
      4'd4:    default_pat = 8'h05;
      4'd5:    default_pat = 8'h06;
      4'd6:    default_pat = 8'h07;
      4'd7:    default_pat = 8'h08;
      4'd8:    default_pat = 8'h09;
      4'd9:    default_pat = 8'h0A;
      4'd10:   default_pat = 8'hFF;
      default: default_pat = 8'h00;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        io_out_d, io_oeb_d;
  logic              busy_d, done_d;
  logic [3:0]        nxt_step;
  logic [7:0]        pat_tbl [NSTEPS];

`ifdef IO_PATTERN_PROG_EN
  // Pattern register file: reloads the default sequence on reset, writable only in IDLE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: this small storage array is reset explicitly because the
    // power-on pattern must be the default sequence, not whatever the flops hold.
    if (wb_rst_i) begin
      for (int i = 0; i < NSTEPS; i++) pat_tbl[i] <= default_pat(4'(i));
    end else if (pat_we && state_q == IDLE && pat_addr < 4'(NSTEPS)) begin
      pat_tbl[pat_addr] <= pat_wdata;
    end
  end
`else
  // Constant pattern ROM.
  always_comb begin
    for (int i = 0; i < NSTEPS; i++) pat_tbl[i] = default_pat(4'(i));
  end
`endif

  assign nxt_step = step_q + 4'd1;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    io_out_d = io_out;
    io_oeb_d = io_oeb;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (start && !abort) begin
          state_d  = RUN;
          step_d   = 4'd0;
          cnt_d    = '0;
          hold_d   = hold_cycles;
          io_out_d = pat_tbl[4'd0];
          io_oeb_d = 8'h00;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d  = IDLE;
          step_d   = 4'd0;
          cnt_d    = '0;
          io_out_d = 8'h00;
          busy_d   = 1'b0;
        end else if (cnt_q == hold_q) begin
          cnt_d = '0;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            step_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d   = nxt_step;
            io_out_d = pat_tbl[nxt_step];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = 4'd0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: non-blocking assignments here so all registers update together
    // from pre-edge values, independent of statement order.
    if (wb_rst_i) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      hold_q  <= '0;
      io_out  <= 8'h00;
      io_oeb  <= 8'hFF;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      io_out  <= io_out_d;
      io_oeb  <= io_oeb_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_io_pattern_gen.sv
// Directed testbench for io_pattern_gen: full runs, hold latching, abort,
// start/abort collision, reset mid-run; pattern writes when IO_PATTERN_PROG_EN.
module tb_io_pattern_gen;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        start;
  logic        abort;
  logic [15:0] hold_cycles;
  logic [7:0]  io_out;
  logic [7:0]  io_oeb;
  logic        busy;
  logic        done;
`ifdef IO_PATTERN_PROG_EN
  logic        pat_we;
  logic [3:0]  pat_addr;
  logic [7:0]  pat_wdata;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_pat [12];

  io_pattern_gen #(.HOLD_W(16), .NSTEPS(12)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .start       (start),
    .abort       (abort),
    .hold_cycles (hold_cycles),
`ifdef IO_PATTERN_PROG_EN
    .pat_we      (pat_we),
    .pat_addr    (pat_addr),
    .pat_wdata   (pat_wdata),
`endif
    .io_out      (io_out),
    .io_oeb      (io_oeb),
    .busy        (busy),
    .done        (done)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one clock; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic load_default();
    exp_pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
  endtask

  // start with hold_cycles=0 and check every step against exp_pat
  task automatic run_hold0(input string tag);
    hold_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_out%0d", tag, i), io_out, exp_pat[i]);
      check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
      tick();
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
    check({tag, "_done_out"}, io_out, exp_pat[11]);
    tick();
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_oeb"}, io_oeb, 8'h00);
  endtask

  initial begin
    int busy_cnt;
    load_default();
    wb_rst_i = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    hold_cycles = 16'd0;
`ifdef IO_PATTERN_PROG_EN
    pat_we = 1'b0;
    pat_addr = 4'd0;
    pat_wdata = 8'h00;
`endif
    tick();
    tick();
    check("rst_out", io_out, 8'h00);
    check("rst_oeb", io_oeb, 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // start+abort together in IDLE: nothing happens, pads stay released
    wb_rst_i = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("collide_busy", busy, 1'b0);
    check("collide_oeb", io_oeb, 8'hFF);
    check("collide_out", io_out, 8'h00);
    tick();
    check("collide_busy2", busy, 1'b0);

    // full run at hold=0
    run_hold0("h0");

    // hold=3 latched; mid-run hold change and start pulse must not matter
    hold_cycles = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 48; c++) begin
      check($sformatf("h3_out%0d", c), io_out, exp_pat[c / 4]);
      if (busy) busy_cnt++;
      if (c == 5) hold_cycles = 16'd0;
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      tick();
    end
    check("h3_busy_cnt", busy_cnt, 48);
    check("h3_done", done, 1'b1);
    check("h3_done_out", io_out, 8'h00);
    tick();
    check("h3_idle_done", done, 1'b0);

    // abort while io_out=0x05
    hold_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("ab_pre_out", io_out, 8'h05);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_out", io_out, 8'h00);
    check("ab_busy", busy, 1'b0);
    check("ab_done", done, 1'b0);
    check("ab_oeb", io_oeb, 8'h00);
    tick();
    check("ab_done2", done, 1'b0);
    check("ab_out2", io_out, 8'h00);
    abort = 1'b1;  // abort in IDLE: no effect
    tick();
    abort = 1'b0;
    check("ab_idle_oeb", io_oeb, 8'h00);
    run_hold0("rerun");

    // reset while io_out=0xFF
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("rf_pre_out", io_out, 8'hFF);
    wb_rst_i = 1'b1;
    #1;
    check("rf_out", io_out, 8'h00);
    check("rf_oeb", io_oeb, 8'hFF);
    check("rf_busy", busy, 1'b0);
    check("rf_done", done, 1'b0);
    tick();
    tick();
    check("rf_hold_done", done, 1'b0);
    // first edge after release accepts start
    wb_rst_i = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rel_busy", busy, 1'b1);
    check("rel_out", io_out, 8'h01);
    check("rel_oeb", io_oeb, 8'h00);
    tick();
    check("rel_out2", io_out, 8'h02);
    for (int i = 0; i < 12; i++) tick();
    check("rel_idle_busy", busy, 1'b0);

`ifdef IO_PATTERN_PROG_EN
    // write addr3 in IDLE, write addr12 (ignored), then run
    pat_we = 1'b1;
    pat_addr = 4'd3;
    pat_wdata = 8'hA5;
    tick();
    pat_addr = 4'd12;
    pat_wdata = 8'h77;
    tick();
    pat_we = 1'b0;
    exp_pat[3] = 8'hA5;
    hold_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pw_out0", io_out, exp_pat[0]);
    pat_we = 1'b1;  // write during RUN: ignored
    pat_addr = 4'd5;
    pat_wdata = 8'h33;
    tick();
    pat_we = 1'b0;
    for (int i = 1; i < 12; i++) begin
      check($sformatf("pw_out%0d", i), io_out, exp_pat[i]);
      tick();
    end
    check("pw_done", done, 1'b1);
    tick();
    run_hold0("pw2");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
